// File: rtl/nextlevel_arbiter_pkg.sv
// nextlevel_arbiter_pkg: shared types and round-robin pick helper for the next-level arbiter
package nextlevel_arbiter_pkg;

    typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2, RFO = 2'd3} op_t;
    typedef logic valid_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, EVICT} arb_state_t;

    localparam int MAX_REQ = 16;
    localparam int IDXW = $clog2(MAX_REQ);

    // first eligible index at or after ptr, wrapping n-1 -> 0; returns ptr when none
    function automatic logic [IDXW-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                input logic [IDXW-1:0] ptr, input int n);
        logic [IDXW:0] idx;
        logic found;
        rr_pick = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (IDXW+1)'(k);
            if (idx >= (IDXW+1)'(n))
                idx = idx - (IDXW+1)'(n);
            if (k < n && !found && eligible[idx[IDXW-1:0]]) begin
                rr_pick = idx[IDXW-1:0];
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/nextlevel_arbiter_if.sv
// nextlevel_arbiter_if: requester-side and next-level-side signals of the arbiter (rq_error only with ARB_TIMEOUT_EN)
interface nextlevel_arbiter_if import nextlevel_arbiter_pkg::*; #(
    parameter int REQ   = 2,
    parameter int ADDRW = 32,
    parameter int DATAW = 512
);
    logic [REQ-1:0]            rq_request;
    op_t  [REQ-1:0]            rq_operation;
    logic [REQ-1:0][ADDRW-1:0] rq_addr;
    logic [REQ-1:0][DATAW-1:0] rq_wdata;
    logic [DATAW-1:0]          rq_rdata;
    logic [REQ-1:0]            rq_valid;
    logic                      rq_evict;
    logic                      nl_request;
    op_t                       nl_operation;
    logic [ADDRW-1:0]          nl_addr;
    logic [DATAW-1:0]          nl_wdata;
    logic [DATAW-1:0]          nl_rdata;
    valid_t                    nl_valid;
    logic                      nl_evict;
`ifdef ARB_TIMEOUT_EN
    logic [REQ-1:0]            rq_error;
`endif

    modport slave (
        input  rq_request, rq_operation, rq_addr, rq_wdata, nl_rdata, nl_valid, nl_evict,
`ifdef ARB_TIMEOUT_EN
        output rq_error,
`endif
        output rq_rdata, rq_valid, rq_evict, nl_request, nl_operation, nl_addr, nl_wdata
    );

    modport master (
        output rq_request, rq_operation, rq_addr, rq_wdata, nl_rdata, nl_valid, nl_evict,
`ifdef ARB_TIMEOUT_EN
        input  rq_error,
`endif
        input  rq_rdata, rq_valid, rq_evict, nl_request, nl_operation, nl_addr, nl_wdata
    );

endinterface

// File: rtl/nextlevel_arbiter_rr_pointer.sv
// nextlevel_arbiter_rr_pointer: round-robin priority pointer, moves one past the finishing owner on advance
module nextlevel_arbiter_rr_pointer #(
    parameter int REQ = 2,
    parameter int PTRW = $clog2(REQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            advance,
    input  logic [PTRW-1:0] owner,
    output logic [PTRW-1:0] ptr
);
    logic [PTRW-1:0] ptr_d, ptr_q;

    // next pointer: owner+1 wrapping REQ-1 -> 0, otherwise hold
    always_comb ptr_d = advance ? ((owner == PTRW'(REQ-1)) ? '0 : owner + PTRW'(1)) : ptr_q;

    // pointer register
    always_ff @(posedge clock or negedge reset)
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;

    assign ptr = ptr_q;

endmodule

// File: rtl/nextlevel_arbiter.sv
// nextlevel_arbiter: round-robin share of one next-level port among REQ caches, one transaction at a time
// Optional ARB_TIMEOUT_EN: abandons a transaction after TMO cycles in WAIT and pulses rq_error.
module nextlevel_arbiter import nextlevel_arbiter_pkg::*; #(
    parameter int REQ   = 2,
    parameter int ADDRW = 32,
    parameter int DATAW = 512
`ifdef ARB_TIMEOUT_EN
    , parameter int TMO = 1024
`endif
) (
    input logic               clock,
    input logic               reset,
    nextlevel_arbiter_if.slave bus
);
    localparam int PTRW = $clog2(REQ);

    arb_state_t       state_d, state_q;
    op_t              op_d, op_q;
    logic [PTRW-1:0]  owner_d, owner_q, ptr, pick;
    logic [ADDRW-1:0] addr_d, addr_q;
    logic [DATAW-1:0] wdata_d, wdata_q, rdata_d, rdata_q;
    logic [REQ-1:0]   eligible, owner_hot;
    logic             grant, active, advance, timeout;

    nextlevel_arbiter_rr_pointer #(.REQ(REQ)) u_ptr (
        .clock  (clock),
        .reset  (reset),
        .advance(advance),
        .owner  (owner_q),
        .ptr    (ptr)
    );

    // a requester competes only when it asks for a real operation
    always_comb begin
        eligible = '0;
        for (int i = 0; i < REQ; i++)
            eligible[i] = bus.rq_request[i] && bus.rq_operation[i] != NOP;
    end

    assign pick      = PTRW'(rr_pick(MAX_REQ'(eligible), IDXW'(ptr), REQ));
    assign grant     = state_q == IDLE && !bus.nl_evict && |eligible;
    assign owner_hot = REQ'(1) << owner_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TMO);
    logic [CNTW-1:0] cnt_d, cnt_q;

    // WAIT cycle counter, cleared on the way into WAIT
    always_comb cnt_d = state_q == ISSUE ? '0 : (state_q == WAIT ? cnt_q + CNTW'(1) : cnt_q);

    // timeout counter register
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign timeout = state_q == WAIT && !bus.nl_valid && cnt_q == CNTW'(TMO-1);
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clock or negedge reset)
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;

    // next state: evict blocks grants only from IDLE, an active transaction always runs to completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.nl_evict ? EVICT : (|eligible ? ISSUE : IDLE);
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = bus.nl_valid ? DONE : (timeout ? IDLE : WAIT);
            DONE:    state_d = IDLE;
            EVICT:   state_d = bus.nl_evict ? EVICT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request is latched at grant; fill data captured when the next level completes
    always_comb begin
        owner_d = grant ? pick : owner_q;
        op_d    = grant ? bus.rq_operation[pick] : op_q;
        addr_d  = grant ? bus.rq_addr[pick] : addr_q;
        wdata_d = grant ? bus.rq_wdata[pick] : wdata_q;
        rdata_d = (state_q == WAIT && bus.nl_valid) ? bus.nl_rdata : rdata_q;
    end

    // latched transaction and fill registers
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            owner_q <= '0;
            op_q    <= NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end

    // outputs decoded from state; completion pulses go only to the owner
    always_comb begin
        active           = state_q == ISSUE || state_q == WAIT;
        advance          = state_q == DONE || timeout;
        bus.nl_request   = active;
        bus.nl_operation = active ? op_q : NOP;
        bus.nl_addr      = addr_q;
        bus.nl_wdata     = wdata_q;
        bus.rq_rdata     = rdata_q;
        bus.rq_valid     = state_q == DONE ? owner_hot : '0;
        bus.rq_evict     = bus.nl_evict;
`ifdef ARB_TIMEOUT_EN
        bus.rq_error     = timeout ? owner_hot : '0;
`endif
    end

endmodule

// File: tb/tb_nextlevel_arbiter.sv
// tb_nextlevel_arbiter: directed checks of grant order, latching, evict handling and (with ARB_TIMEOUT_EN) timeout
module tb_nextlevel_arbiter;
    import nextlevel_arbiter_pkg::*;

    localparam int DATAW = 512;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [1:0][DATAW-1:0] wd;

    nextlevel_arbiter_if #(.REQ(2), .ADDRW(32), .DATAW(DATAW)) bus ();

    nextlevel_arbiter #(
        .REQ(2), .ADDRW(32), .DATAW(DATAW)
`ifdef ARB_TIMEOUT_EN
        , .TMO(16)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_txn(input int who, input op_t op, input logic [31:0] addr, input logic [DATAW-1:0] data);
        int n = 0;
        while (!bus.nl_request && n < 8) begin
            tick();
            n++;
        end
        check("grant_seen", bus.nl_request, 1);
        check("nl_addr", bus.nl_addr, addr);
        check("nl_op", bus.nl_operation, op);
        check("nl_wdata", bus.nl_wdata, wd[who]);
        bus.rq_request[who] = 1'b0;
        tick();
        bus.nl_valid = 1'b1;
        bus.nl_rdata = data;
        tick();
        check("rq_valid", bus.rq_valid, 2'b01 << who);
        check("nl_req_drop", bus.nl_request, 0);
        if (op != WRITE) check("rq_rdata", bus.rq_rdata, data);
        bus.nl_valid = 1'b0;
        tick();
        check("rq_valid_clr", bus.rq_valid, 0);
    endtask

    initial begin
        wd[0] = {16{32'h0D0D_0D0D}};
        wd[1] = {16{32'h1111_1111}};
        bus.rq_request = '0;
        bus.rq_operation[0] = NOP;
        bus.rq_operation[1] = NOP;
        bus.rq_addr = '0;
        bus.rq_wdata = wd;
        bus.nl_rdata = '0;
        bus.nl_valid = 1'b0;
        bus.nl_evict = 1'b0;
        repeat (3) tick();
        check("rst_nl_request", bus.nl_request, 0);
        check("rst_nl_op", bus.nl_operation, NOP);
        check("rst_rq_valid", bus.rq_valid, 0);
        check("rst_rq_rdata", bus.rq_rdata, 0);
        reset = 1'b1;
        tick();

        // single READ from requester 0, grant latency and fill routing
        bus.rq_operation[0] = READ;
        bus.rq_addr[0] = 32'h0000_1000;
        bus.rq_request[0] = 1'b1;
        check("pre_grant", bus.nl_request, 0);
        tick();
        check("grant_latency", bus.nl_request, 1);
        run_txn(0, READ, 32'h0000_1000, {64{8'hA5}});

        // nl_valid outside WAIT is ignored and rq_rdata holds
        bus.nl_valid = 1'b1;
        bus.nl_rdata = {64{8'hFF}};
        tick();
        bus.nl_valid = 1'b0;
        check("stray_valid", bus.rq_valid, 0);
        check("rdata_hold", bus.rq_rdata, {64{8'hA5}});

        // NOP request is never granted
        bus.rq_operation[1] = NOP;
        bus.rq_request[1] = 1'b1;
        repeat (3) tick();
        check("nop_ignored", bus.nl_request, 0);
        bus.rq_request[1] = 1'b0;

        // reset during WAIT aborts immediately
        bus.rq_operation[1] = READ;
        bus.rq_addr[1] = 32'h0000_2000;
        bus.rq_request[1] = 1'b1;
        tick();
        bus.rq_request[1] = 1'b0;
        tick();
        check("in_wait", bus.nl_request, 1);
        reset = 1'b0;
        #1;
        check("abort_nl_request", bus.nl_request, 0);
        check("abort_rq_valid", bus.rq_valid, 0);
        check("abort_nl_op", bus.nl_operation, NOP);
        tick();
        reset = 1'b1;
        tick();

        // simultaneous requests: ptr=0 after reset gives 0 then 1
        bus.rq_operation[0] = READ;
        bus.rq_addr[0] = 32'h0000_3000;
        bus.rq_addr[1] = 32'h0000_4000;
        bus.rq_request = 2'b11;
        run_txn(0, READ, 32'h0000_3000, {64{8'h01}});
        run_txn(1, READ, 32'h0000_4000, {64{8'h02}});
        bus.rq_addr[0] = 32'h0000_3100;
        bus.rq_request[0] = 1'b1;
        run_txn(0, READ, 32'h0000_3100, {64{8'h03}});
        bus.rq_request = 2'b11;
        run_txn(1, READ, 32'h0000_4000, {64{8'h04}});
        run_txn(0, READ, 32'h0000_3100, {64{8'h05}});

        // evict in IDLE blocks the pending WRITE until it drops
        bus.nl_evict = 1'b1;
        bus.rq_operation[1] = WRITE;
        bus.rq_addr[1] = 32'h0000_5000;
        bus.rq_request[1] = 1'b1;
        #1;
        check("rq_evict_on", bus.rq_evict, 1);
        tick();
        check("evict_no_grant_a", bus.nl_request, 0);
        tick();
        check("evict_no_grant_b", bus.nl_request, 0);
        bus.nl_evict = 1'b0;
        #1;
        check("rq_evict_off", bus.rq_evict, 0);
        tick();
        run_txn(1, WRITE, 32'h0000_5000, {16{32'hDEAD_BEEF}});

        // evict during WAIT does not abort; requester drop mid-WAIT still completes
        bus.rq_operation[1] = READ;
        bus.rq_addr[1] = 32'h0000_7000;
        bus.rq_request[1] = 1'b1;
        tick();
        tick();
        bus.nl_evict = 1'b1;
        tick();
        check("evict_no_abort", bus.nl_request, 1);
        check("rq_evict_wait", bus.rq_evict, 1);
        bus.rq_request[1] = 1'b0;
        bus.nl_valid = 1'b1;
        bus.nl_rdata = {64{8'h3C}};
        tick();
        check("drop_rq_valid", bus.rq_valid, 2'b10);
        check("drop_rq_rdata", bus.rq_rdata, {64{8'h3C}});
        bus.nl_valid = 1'b0;
        bus.rq_addr[0] = 32'h0000_7100;
        bus.rq_request[0] = 1'b1;
        tick();
        check("done_to_idle", bus.rq_valid, 0);
        tick();
        check("evict_after_a", bus.nl_request, 0);
        tick();
        check("evict_after_b", bus.nl_request, 0);
        bus.nl_evict = 1'b0;
        tick();
        run_txn(0, READ, 32'h0000_7100, {64{8'h5A}});

        // stalled next level
        bus.rq_addr[1] = 32'h0000_8000;
        bus.rq_request[1] = 1'b1;
        tick();
        bus.rq_request[1] = 1'b0;
        tick();
`ifdef ARB_TIMEOUT_EN
        repeat (14) tick();
        check("tmo_wait15_err", bus.rq_error, 0);
        check("tmo_wait15_req", bus.nl_request, 1);
        tick();
        check("tmo_error", bus.rq_error, 2'b10);
        check("tmo_no_valid", bus.rq_valid, 0);
        tick();
        check("tmo_req_drop", bus.nl_request, 0);
        check("tmo_error_clr", bus.rq_error, 0);
        bus.rq_request = 2'b11;
        run_txn(0, READ, 32'h0000_7100, {64{8'h66}});
        run_txn(1, READ, 32'h0000_8000, {64{8'h77}});
`else
        repeat (999) tick();
        check("stall_req_1000", bus.nl_request, 1);
        check("stall_valid_1000", bus.rq_valid, 0);
        bus.nl_valid = 1'b1;
        bus.nl_rdata = {64{8'h77}};
        tick();
        check("stall_done", bus.rq_valid, 2'b10);
        bus.nl_valid = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
